// File: rtl/crack_sched.sv
`default_nettype none
// ============================================================================
// Module   : crack_sched
// Purpose  : Two-core ARC4 key-search scheduler (even/odd key split) with a
//            round-robin arbiter for the shared ciphertext memory port.
// Revision : 1.0
// ============================================================================
module crack_sched #(
    parameter int KEY_W = 24,
    parameter int CT_AW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             rdy,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,

    output logic             c0_en,
    input  logic             c0_rdy,
    output logic [KEY_W-1:0] c0_start_key,
    output logic             c0_abort,
    input  logic [KEY_W-1:0] c0_key,
    input  logic             c0_key_valid,
    input  logic             c0_ct_req,
    input  logic [CT_AW-1:0] c0_ct_addr,
    output logic             c0_ct_gnt,
    output logic             c0_ct_rvalid,

    output logic             c1_en,
    input  logic             c1_rdy,
    output logic [KEY_W-1:0] c1_start_key,
    output logic             c1_abort,
    input  logic [KEY_W-1:0] c1_key,
    input  logic             c1_key_valid,
    input  logic             c1_ct_req,
    input  logic [CT_AW-1:0] c1_ct_addr,
    output logic             c1_ct_gnt,
    output logic             c1_ct_rvalid,

    output logic [7:0]       ct_rddata_o,
    output logic [CT_AW-1:0] ct_addr,
    input  logic [7:0]       ct_rddata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [1:0]       r_state;
    logic             r_first;
    logic             r_fin0;
    logic             r_fin1;
    logic             r_en;
    logic             r_abort0;
    logic             r_abort1;
    logic [KEY_W-1:0] r_key;
    logic             r_key_valid;

    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_rvalid0;
    logic             r_rvalid1;
    logic             r_rr_ptr;
    logic [CT_AW-1:0] r_ct_addr;
    logic [7:0]       r_rddata;

    logic w_done0;
    logic w_done1;
    logic w_win0;
    logic w_win1;
    logic w_fin0_nx;
    logic w_fin1_nx;
    logic w_elig0;
    logic w_elig1;
    logic w_pick0;
    logic w_pick1;

    // Cores still show rdy=1 in the first RUN cycle, so that sample is masked.
    assign w_done0   = (r_state == S_RUN) && !r_first && !r_fin0 && c0_rdy;
    assign w_done1   = (r_state == S_RUN) && !r_first && !r_fin1 && c1_rdy;
    assign w_win0    = w_done0 && c0_key_valid;
    assign w_win1    = w_done1 && c1_key_valid && !w_win0;
    assign w_fin0_nx = r_fin0 | w_done0;
    assign w_fin1_nx = r_fin1 | w_done1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_first     <= 1'b0;
            r_fin0      <= 1'b0;
            r_fin1      <= 1'b0;
            r_en        <= 1'b0;
            r_abort0    <= 1'b0;
            r_abort1    <= 1'b0;
            r_key       <= '0;
            r_key_valid <= 1'b0;
        end else begin
            r_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_key       <= '0;
                        r_key_valid <= 1'b0;
                        r_state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (c0_rdy && c1_rdy) begin
                        r_en    <= 1'b1;
                        r_first <= 1'b1;
                        r_fin0  <= 1'b0;
                        r_fin1  <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_first <= 1'b0;
                    r_fin0  <= w_fin0_nx;
                    r_fin1  <= w_fin1_nx;
                    if (w_win0) begin
                        r_key       <= c0_key;
                        r_key_valid <= 1'b1;
                        // Only a core still searching needs to be aborted.
                        if (!w_fin1_nx) begin
                            r_abort1 <= 1'b1;
                            r_state  <= S_STOP;
                        end else begin
                            r_state  <= S_IDLE;
                        end
                    end else if (w_win1) begin
                        r_key       <= c1_key;
                        r_key_valid <= 1'b1;
                        if (!w_fin0_nx) begin
                            r_abort0 <= 1'b1;
                            r_state  <= S_STOP;
                        end else begin
                            r_state  <= S_IDLE;
                        end
                    end else if (w_fin0_nx && w_fin1_nx) begin
                        r_key       <= '0;
                        r_key_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_STOP: begin
                    if ((r_abort0 && c0_rdy) || (r_abort1 && c1_rdy)) begin
                        r_abort0 <= 1'b0;
                        r_abort1 <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // A core holding its grant this cycle is masked so one request is never granted twice.
    assign w_elig0 = c0_ct_req && !r_gnt0;
    assign w_elig1 = c1_ct_req && !r_gnt1;
    assign w_pick1 = w_elig1 && (!w_elig0 || r_rr_ptr);
    assign w_pick0 = w_elig0 && !w_pick1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rr_ptr  <= 1'b0;
            r_ct_addr <= '0;
            r_rddata  <= '0;
        end else begin
            r_gnt0    <= w_pick0;
            r_gnt1    <= w_pick1;
            r_rvalid0 <= r_gnt0;
            r_rvalid1 <= r_gnt1;
            if (w_pick0) begin
                r_ct_addr <= c0_ct_addr;
                r_rr_ptr  <= 1'b1;
            end else if (w_pick1) begin
                r_ct_addr <= c1_ct_addr;
                r_rr_ptr  <= 1'b0;
            end
            if (r_gnt0 || r_gnt1) begin
                r_rddata <= ct_rddata;
            end
        end
    end

    assign rdy          = (r_state == S_IDLE);
    assign key          = r_key;
    assign key_valid    = r_key_valid;
    assign c0_en        = r_en;
    assign c1_en        = r_en;
    assign c0_start_key = '0;
    assign c1_start_key = KEY_W'(1);
    assign c0_abort     = r_abort0;
    assign c1_abort     = r_abort1;
    assign c0_ct_gnt    = r_gnt0;
    assign c1_ct_gnt    = r_gnt1;
    assign c0_ct_rvalid = r_rvalid0;
    assign c1_ct_rvalid = r_rvalid1;
    assign ct_addr      = r_ct_addr;
    assign ct_rddata_o  = r_rddata;

endmodule
`default_nettype wire

// File: doc/crack_sched.md
# crack_sched

Two-core ARC4 key-search scheduler and ciphertext-memory arbiter. It sits between the top-level cracking interface and two `crack` engines. On start it splits the 24-bit key space between them: core 0 takes even keys, core 1 takes odd keys. It shares the single ciphertext memory port between the two cores, reports the first key found, and aborts the losing core.

## Interface
Parameters:
- KEY_W, 24, key width
- CT_AW, 8, ciphertext address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  start request; accepted only when rdy=1
- rdy  out  1  scheduler idle, can accept en
- key  out  KEY_W  found key; valid when key_valid=1
- key_valid  out  1  key found in the last search
- cN_en  out  1  (N=0,1) one-cycle start pulse to core N
- cN_rdy  in  1  core N idle/finished
- cN_start_key  out  KEY_W  first key for core N: constant 0 for N=0, 1 for N=1; stride is fixed at 2 inside the core
- cN_abort  out  1  level; core N must stop and return cN_rdy=1
- cN_key  in  KEY_W  core N's result key
- cN_key_valid  in  1  core N found a key; sampled when cN_rdy rises
- cN_ct_req  in  1  core N read request
- cN_ct_addr  in  CT_AW  core N read address
- cN_ct_gnt  out  1  one-cycle grant pulse
- cN_ct_rvalid  out  1  read data valid for core N
- ct_rddata_o  out  8  read data broadcast to both cores
- ct_addr  out  CT_AW  ciphertext memory address
- ct_rddata  in  8  memory data, one cycle after ct_addr

## Operation
FSM states: IDLE, LAUNCH, RUN, STOP.

**IDLE** (rdy=1)
- en=1 → clear key and key_valid, go to LAUNCH.

**LAUNCH** (rdy=0)
- Wait until c0_rdy=c1_rdy=1.
- Then pulse c0_en and c1_en together for one cycle and go to RUN.

**RUN**
- Ignore cN_rdy in the first RUN cycle; cores drop rdy the cycle after en.
- A core is done when cN_rdy=1 is sampled after that first cycle.
- Core N done with cN_key_valid=1: latch key=cN_key, set key_valid=1, assert abort to the other core, go to STOP.
- Both done in the same cycle with both valid: core 0 wins.
- Core done with cN_key_valid=0: mark it finished and keep waiting.
- Both finished, none valid: key_valid=0, key=0, go to IDLE.

**STOP**
- Hold cN_abort=1 to the unfinished core until its cN_rdy=1, then deassert and go to IDLE.

**General rules**
- en outside IDLE is ignored.
- key and key_valid hold until the next accepted en.

**Memory arbiter** (active in all states)
- Requester eligible: cN_ct_req=1 and cN_ct_gnt=0 in the current cycle. The current grant is masked to prevent double-grant.
- Registered round-robin: when both are eligible, grant the core not granted last. The pointer resets to favour core 0.
- Grant edge: cN_ct_gnt=1 and ct_addr=cN_ct_addr are registered together.
- Next cycle: ct_rddata_o=ct_rddata and cN_ct_rvalid=1 for the granted core.
- Requesters hold req and addr until gnt. Throughput is one grant per cycle.
- cN_abort does not cancel an in-flight read; its rvalid still issues.

## Timing
- Reset values: rdy=1; key=0; key_valid=0. All cN_en, cN_abort, cN_ct_gnt and cN_ct_rvalid are 0. ct_addr=0, ct_rddata_o=0, round-robin pointer = core 0, state IDLE.
- Start latency: en at edge k, cores idle → LAUNCH at k+1 → cN_en high during cycle k+1→k+2.
- Result latency: cN_rdy rising with valid sampled at edge m → key/key_valid updated at m+1, abort asserted from m+1.
- rdy returns to 1 the cycle after the last core reports rdy.
- Read latency: req seen at edge t → gnt and ct_addr at t+1 → rvalid and data at t+2.
- Reset asserted mid-search: all outputs go immediately to reset values; no abort is issued.

## Test plan
- Reset, then en pulse with both cores idle → c0_en and c1_en pulse together 2 cycles after en; c0_start_key=0, c1_start_key=1; rdy=0.
- Core 1 finishes with key 24'h00_3A_4B valid, core 0 still busy → key=24'h003A4B, key_valid=1, c0_abort=1 until c0_rdy=1, then rdy=1.
- Both cores finish in the same cycle, valid keys 24'h000010 (core 0) and 24'h000011 (core 1) → key=24'h000010.
- Both cores finish with cN_key_valid=0 → key_valid=0, key=0, rdy=1, no abort pulsed.
- Both cores hold req continuously, addrs 8'h05 and 8'h09 → grants alternate c0,c1,c0,… one per cycle. ct_addr follows the grants, rvalid lands one cycle after each gnt, and there are no duplicate grants.
- rst_n=0 during RUN → rdy=1, key_valid=0, all enables/grants 0 asynchronously; a fresh en after release starts normally.
